// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: phase state codes and
// the default instruction size.
package mc_sequencer_pkg;

  localparam int STATE_W             = 3;
  localparam int DEFAULT_INSTR_BYTES = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } state_t;

endpackage

// File: rtl/mc_sequencer_pc_unit.sv
// Program counter with next-PC selection. The FSM supplies the load enable
// and the target/sequential select; the target is aligned to an instruction
// boundary by clearing its low address bits.
module mc_sequencer_pc_unit
  import mc_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET    = '0,
  parameter int              INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            load,
  input  logic            sel_target,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] aligned_target;
  logic [XLEN-1:0] next_pc;

  // Sequential successor wraps naturally modulo 2^XLEN; target is forced
  // onto an instruction boundary before it can reach the PC.
  always_comb begin
    seq_pc         = pc + STEP;
    aligned_target = target & ALIGN_MASK;
    next_pc        = sel_target ? aligned_target : seq_pc;
  end

  // PC register: only moves when an instruction completes.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      pc <= PC_RESET;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle CPU sequencer. An explicit phase FSM walks each instruction
// through FETCH/DECODE/EXECUTE and, depending on its class, MEM and/or WB.
// Both memories are handshaked, so FETCH and MEM can stretch for any number
// of wait cycles. All strobes and requests are registered.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET    = '0,
  parameter int              INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int              CNT_W       = 16
) (
  input  logic               clk,
  input  logic               nreset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    ir,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_branch,
  input  logic               is_jump,
  input  logic               is_halt,
  input  logic               branch_taken,
  input  logic [XLEN-1:0]    target,
  output logic               rf_re,
  output logic               rf_we,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic [XLEN-1:0]    pc,
  output logic [STATE_W-1:0] state,
  output logic               retire,
  output logic [CNT_W-1:0]   retired_cnt,
  output logic               halted
);

  state_t st;

  logic mem_op;
  logic ctl_op;
  logic take_target;
  logic complete;

  // Instruction classification and the completion condition. Memory ops
  // take precedence over control-flow flags when the decoder reports both.
  always_comb begin
    mem_op      = is_load | is_store;
    ctl_op      = is_branch | is_jump;
    take_target = 1'b0;
    complete    = 1'b0;
    unique case (st)
      ST_EXECUTE: begin
        complete    = !mem_op && ctl_op;
        take_target = !mem_op && (is_jump || (is_branch && branch_taken));
      end
      ST_MEM:  complete = dmem_ack && dmem_we;
      ST_WB:   complete = 1'b1;
      default: complete = 1'b0;
    endcase
  end

  mc_sequencer_pc_unit #(
    .XLEN        (XLEN),
    .PC_RESET    (PC_RESET),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_unit (
    .clk        (clk),
    .nreset     (nreset),
    .load       (complete),
    .sel_target (take_target),
    .target     (target),
    .pc         (pc)
  );

  assign imem_addr = pc;
  assign state     = st;

  // Phase FSM with registered strobes, IR capture and retirement counting.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      st          <= ST_IDLE;
      ir          <= '0;
      retired_cnt <= '0;
      imem_req    <= 1'b0;
      rf_re       <= 1'b0;
      rf_we       <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      retire      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      rf_re  <= 1'b0;
      rf_we  <= 1'b0;
      retire <= 1'b0;

      if (complete) begin
        retire      <= 1'b1;
        retired_cnt <= retired_cnt + CNT_W'(1);
      end

      unique case (st)
        ST_IDLE: begin
          st       <= ST_FETCH;
          imem_req <= 1'b1;
        end

        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            rf_re    <= 1'b1;
            st       <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (is_halt) begin
            halted <= 1'b1;
            st     <= ST_HALT;
          end else begin
            st <= ST_EXECUTE;
          end
        end

        ST_EXECUTE: begin
          if (mem_op) begin
            dmem_req <= 1'b1;
            dmem_we  <= is_store;
            st       <= ST_MEM;
          end else if (ctl_op) begin
            imem_req <= 1'b1;
            st       <= ST_FETCH;
          end else begin
            rf_we <= 1'b1;
            st    <= ST_WB;
          end
        end

        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              imem_req <= 1'b1;
              st       <= ST_FETCH;
            end else begin
              rf_we <= 1'b1;
              st    <= ST_WB;
            end
          end
        end

        ST_WB: begin
          imem_req <= 1'b1;
          st       <= ST_FETCH;
        end

        ST_HALT: begin
          st <= ST_HALT;
        end

        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          st       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer: table of single-instruction vectors driven
// through handshaked memories, with a scoreboard of expected retirement
// results, plus sequences for counter wrap, mid-fetch reset and HALT.
module tb_mc_sequencer;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;

  localparam int C_ALU    = 0;
  localparam int C_LOAD   = 1;
  localparam int C_STORE  = 2;
  localparam int C_BRANCH = 3;
  localparam int C_JUMP   = 4;
  localparam int C_CONF   = 5;  // load and branch flags both set

  logic             clk = 1'b0;
  logic             nreset = 1'b1;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic             imem_ack = 1'b0;
  logic [XLEN-1:0]  imem_rdata = '0;
  logic [XLEN-1:0]  ir;
  logic             is_load = 1'b0;
  logic             is_store = 1'b0;
  logic             is_branch = 1'b0;
  logic             is_jump = 1'b0;
  logic             is_halt = 1'b0;
  logic             branch_taken = 1'b0;
  logic [XLEN-1:0]  target = '0;
  logic             rf_re;
  logic             rf_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack = 1'b0;
  logic [XLEN-1:0]  pc;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             halted;

  mc_sequencer #(
    .XLEN        (XLEN),
    .PC_RESET    (32'h0),
    .INSTR_BYTES (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .nreset       (nreset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_branch    (is_branch),
    .is_jump      (is_jump),
    .is_halt      (is_halt),
    .branch_taken (branch_taken),
    .target       (target),
    .rf_re        (rf_re),
    .rf_we        (rf_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .pc           (pc),
    .state        (state),
    .retire       (retire),
    .retired_cnt  (retired_cnt),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cls;
    int          iw;       // imem wait cycles
    int          dw;       // dmem wait cycles
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] word;
    int          exp_cyc;  // cycles from FETCH entry to retirement
    int          exp_we;   // number of rf_we pulses
  } vec_t;

  typedef struct {
    logic [31:0]      pc;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ir;
    int               cyc;
    int               we;
  } sb_t;

  sb_t              sb[$];
  vec_t             vt[13];
  logic [31:0]      mpc;
  logic [CNT_W-1:0] mcnt;
  int               n_pass = 0;
  int               n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction from FETCH to retirement and score it.
  task automatic run_instr(input vec_t v, input int idx);
    sb_t         e;
    sb_t         got;
    int          cyc;
    int          fw;
    int          dwc;
    int          we_n;
    int          re_n;
    bit          hold_ok;
    bit          done;
    logic [31:0] pc0;
    logic        exp_st;

    is_load      = (v.cls == C_LOAD) || (v.cls == C_CONF);
    is_store     = (v.cls == C_STORE);
    is_branch    = (v.cls == C_BRANCH) || (v.cls == C_CONF);
    is_jump      = (v.cls == C_JUMP);
    is_halt      = 1'b0;
    branch_taken = v.taken;
    target       = v.tgt;
    exp_st       = is_store;

    if (is_load || is_store) mpc = mpc + 32'd4;
    else if (is_jump || (is_branch && v.taken)) mpc = v.tgt & ~32'h3;
    else mpc = mpc + 32'd4;
    mcnt  = mcnt + 1'b1;
    e.pc  = mpc;
    e.cnt = mcnt;
    e.ir  = v.word;
    e.cyc = v.exp_cyc;
    e.we  = v.exp_we;
    sb.push_back(e);

    pc0 = pc; cyc = 0; fw = 0; dwc = 0; we_n = 0; re_n = 0;
    hold_ok = 1'b1; done = 1'b0;
    while (!done && cyc < 60) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      if (state == 3'd1) begin
        if (imem_req !== 1'b1 || imem_addr !== pc0) hold_ok = 1'b0;
        if (fw == v.iw) begin
          imem_ack   = 1'b1;
          imem_rdata = v.word;
        end else begin
          imem_rdata = ~v.word;
        end
        fw++;
      end
      if (state == 3'd4) begin
        if (dmem_req !== 1'b1 || dmem_we !== exp_st || imem_req !== 1'b0 || pc !== pc0)
          hold_ok = 1'b0;
        if (dwc == v.dw) dmem_ack = 1'b1;
        dwc++;
      end
      if (rf_we === 1'b1) we_n++;
      if (rf_re === 1'b1) re_n++;
      tick();
      cyc++;
      if (retire === 1'b1) done = 1'b1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    got = sb.pop_front();
    if (!done) begin
      check($sformatf("v%0d_retire_timeout", idx), 32'(done), 32'd1);
      mpc  = pc;
      mcnt = retired_cnt;
    end else begin
      check($sformatf("v%0d_pc", idx), pc, got.pc);
      check($sformatf("v%0d_cnt", idx), 32'(retired_cnt), 32'(got.cnt));
      check($sformatf("v%0d_ir", idx), ir, got.ir);
      check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(got.cyc));
      check($sformatf("v%0d_rf_we", idx), 32'(we_n), 32'(got.we));
      check($sformatf("v%0d_rf_re", idx), 32'(re_n), 32'd1);
      check($sformatf("v%0d_hold", idx), 32'(hold_ok), 32'd1);
      check($sformatf("v%0d_state", idx), 32'(state), 32'd1);
    end
  endtask

  initial begin
    vec_t        j0;
    bit          bad;
    logic [31:0] pc_h;

    //          cls       iw dw tk    tgt            word          cyc we
    vt[0]  = '{C_ALU,    0, 0, 1'b0, 32'h0,         32'hA000_0000, 4, 1};
    vt[1]  = '{C_LOAD,   0, 3, 1'b0, 32'h0,         32'hA000_0001, 8, 1};
    vt[2]  = '{C_STORE,  0, 0, 1'b0, 32'h0,         32'hA000_0002, 4, 0};
    vt[3]  = '{C_JUMP,   0, 0, 1'b0, 32'h10,        32'hA000_0003, 3, 0};
    vt[4]  = '{C_BRANCH, 0, 0, 1'b1, 32'h43,        32'hA000_0004, 3, 0};
    vt[5]  = '{C_JUMP,   0, 0, 1'b0, 32'h12,        32'hA000_0005, 3, 0};
    vt[6]  = '{C_BRANCH, 0, 0, 1'b0, 32'h80,        32'hA000_0006, 3, 0};
    vt[7]  = '{C_ALU,    2, 0, 1'b0, 32'h0,         32'hA000_0007, 6, 1};
    vt[8]  = '{C_LOAD,   1, 0, 1'b0, 32'h0,         32'hA000_0008, 6, 1};
    vt[9]  = '{C_STORE,  0, 2, 1'b0, 32'h0,         32'hA000_0009, 6, 0};
    vt[10] = '{C_CONF,   0, 0, 1'b1, 32'h100,       32'hA000_000A, 5, 1};
    vt[11] = '{C_JUMP,   0, 0, 1'b0, 32'hFFFF_FFFF, 32'hA000_000B, 3, 0};
    vt[12] = '{C_ALU,    0, 0, 1'b0, 32'h0,         32'hA000_000C, 4, 1};

    // Reset values
    mpc  = 32'h0;
    mcnt = '0;
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_cnt", 32'(retired_cnt), 32'd0);
    check("rst_strobes", 32'({imem_req, rf_re, rf_we, dmem_req, dmem_we, retire, halted}), 32'd0);
    nreset = 1'b0;
    check("idle_after_release", 32'(state), 32'd0);
    tick();
    check("fetch_after_idle", 32'(state), 32'd1);
    check("fetch_addr", imem_addr, 32'h0);

    // Table of single instructions
    for (int i = 0; i < 13; i++) run_instr(vt[i], i);

    // Retired counter wrap: jumps to 0 until the counter rolls over
    j0 = '{C_JUMP, 0, 0, 1'b0, 32'h0, 32'hB000_0000, 3, 0};
    for (int i = 13; i < (1 << CNT_W); i++) run_instr(j0, i);
    check("cnt_wrapped", 32'(retired_cnt), 32'd0);

    // Reset asserted while FETCH is waiting on imem_ack
    imem_ack = 1'b0;
    tick();
    check("fetch_wait_req", 32'(imem_req), 32'd1);
    nreset = 1'b1;
    #1;
    check("async_req_drop", 32'(imem_req), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_cnt", 32'(retired_cnt), 32'd0);
    mpc  = 32'h0;
    mcnt = '0;
    tick();
    nreset = 1'b0;
    check("idle_after_rst2", 32'(state), 32'd0);
    imem_ack   = 1'b1;
    dmem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check("stray_ack_ir", ir, 32'h0);
    check("fetch_after_rst2", 32'(state), 32'd1);
    check("fetch_addr_rst2", imem_addr, 32'h0);

    // HALT: absorbing, no requests, no retirement, acks ignored
    is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
    is_halt    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0073;
    for (int i = 0; i < 10 && state != 3'd6; i++) begin
      tick();
      imem_ack = 1'b0;
    end
    check("halt_state", 32'(state), 32'd6);
    check("halted", 32'(halted), 32'd1);
    pc_h = pc;
    bad  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      tick();
      if (imem_req || dmem_req || retire || rf_we || rf_re || state != 3'd6 || !halted)
        bad = 1'b1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    check("halt_quiet", 32'(bad), 32'd0);
    check("halt_cnt", 32'(retired_cnt), 32'(mcnt));
    check("halt_ir", ir, 32'h0000_0073);
    check("halt_pc", pc, pc_h);
    nreset = 1'b1;
    #1;
    check("halt_exit_rst", 32'(halted), 32'd0);
    nreset  = 1'b0;
    is_halt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised multi-cycle CPU sequencer. It replaces the fixed 4-phase modulo counter with an explicit phase FSM.
- Owns the PC, the instruction register (IR) and the retired-instruction counter.
- Phase length varies by instruction class: memory phase skipped for non-memory ops, writeback skipped for stores and branches.
- Instruction and data memories are accessed through req/ack handshakes, so both can insert wait states. Sits between the memories, the control decoder and the register file / ALU datapath.

Parameters:
- XLEN, 32, datapath / PC / IR width.
- PC_RESET, 0, PC value loaded on reset.
- INSTR_BYTES, 4, PC increment; power of two.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- nreset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  XLEN  fetched instruction.
- ir  out  XLEN  instruction register; feeds decoder.
- is_load, is_store, is_branch, is_jump, is_halt  in  1 each  decoded class of ir; valid from DECODE onward.
- branch_taken  in  1  ALU zero/condition result; valid in EXECUTE.
- target  in  XLEN  branch/jump target; valid in EXECUTE.
- rf_re  out  1  register-file read strobe.
- rf_we  out  1  register-file write strobe.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store qualifier; meaningful only while dmem_req=1.
- dmem_ack  in  1  data access complete.
- pc  out  XLEN  current PC.
- state  out  3  FSM state code.
- retire  out  1  one-cycle pulse when an instruction completes.
- retired_cnt  out  CNT_W  retired instruction count.
- halted  out  1  high in HALT.

Behaviour:
- Reset values (asynchronous, nreset=1):
  - state=IDLE, pc=PC_RESET, ir=0, retired_cnt=0.
  - All strobes, requests and retire=0; halted=0.
  - Outstanding requests drop immediately; a mid-transaction reset abandons it.
- State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc, held stable until ack.
  - On imem_ack: ir<=imem_rdata, go to DECODE. Ack in the first FETCH cycle is accepted (zero wait).
- DECODE:
  - rf_re=1 for one cycle.
  - is_halt goes to HALT; otherwise EXECUTE.
- EXECUTE, one cycle, priority:
  - is_load or is_store: go to MEM.
  - is_branch or is_jump: retire, pc<=next_pc, go to FETCH.
  - otherwise: go to WB.
- MEM:
  - dmem_req=1, dmem_we=is_store, held until dmem_ack.
  - Store on ack: retire, pc<=pc+INSTR_BYTES, go to FETCH.
  - Load on ack: go to WB.
- WB: rf_we=1 for one cycle, retire, pc<=pc+INSTR_BYTES, go to FETCH.
- HALT: absorbing; halted=1, no requests issued; exit only by reset.
- next_pc:
  - is_jump, or is_branch with branch_taken: target with low log2(INSTR_BYTES) bits forced to 0.
  - otherwise: pc+INSTR_BYTES.
  - pc arithmetic wraps modulo 2^XLEN.
- retire pulses exactly once per completed instruction. retired_cnt increments on retire and wraps at 2^CNT_W. HALT does not retire.
- Acks arriving while the matching req=0 are ignored.
- ir changes only on an accepted fetch.
- Latency with zero-wait memories:
  - ALU op: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch/jump: 3 cycles.
  - Each memory wait cycle adds 1.
- Conflicting decode flags (e.g. is_load and is_branch both set): the memory class wins.

Decomposition:
- Shared package: state code constants and their width; default INSTR_BYTES.
- One sub-module, pc_unit: holds the pc register, the next-PC mux and target alignment. Load enable and select come from the FSM.

Test Plan:
- Reset then ALU op at pc=0, zero-wait memories: FETCH→DECODE→EXECUTE→WB. rf_we pulses in cycle 4, pc=4, retired_cnt=1.
- Load with dmem_ack delayed 3 cycles: dmem_req held 4 cycles with stable outputs, WB follows, pc advances by 4. Total 8 cycles.
- Branch at pc=0x10, branch_taken=1, target=0x43: pc=0x40 after 3 cycles, no rf_we. Same with branch_taken=0: pc=0x14.
- pc=0xFFFFFFFC with an ALU op: pc wraps to 0x00000000. Preset retired_cnt=0xFFFF, retire → 0x0000.
- Assert nreset during a FETCH wait: imem_req drops the same cycle. After release: IDLE one cycle, then FETCH at PC_RESET.
- is_halt decoded: enters HALT, halted=1. No imem_req for 20 cycles and retired_cnt unchanged. Stray acks ignored.
